serial_wide_comparator: RTL and testbench

- Multi-cycle magnitude comparator for WIDTH-bit unsigned operands.
- Feeds one 4-bit nibble pair per cycle, LSB nibble first, into a combinational 4-bit cascade comparator stage.
- Registers that stage's Lt/Gt/Eq outputs each cycle and feeds them back as its cascade inputs for the next, more significant nibble.
- Sits directly around the 4-bit cascade comparator and sequences it, so wide compares reuse one 4-bit comparator slice.

---
 rtl/cmp_pkg.sv | 21 ++
 rtl/serial_wide_comparator_stage.sv | 26 ++
 rtl/serial_wide_comparator.sv | 130 +++++++++++++
 tb/tb_serial_wide_comparator.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types for the serial wide comparator.
//   state_t   : sequencer states (IDLE, RUN, DONE)
//   NIBBLE_W  : width of the slice compared per cycle
//   cascade_t : packed {lt, gt, eq} cascade / result triple, lt in the MSB
package cmp_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic lt;
        logic gt;
        logic eq;
    } cascade_t;

endpackage

// File: rtl/serial_wide_comparator_stage.sv
// nibble_cmp_stage: combinational 4-bit magnitude comparator slice with
// cascade inputs.
//   a_n, b_n  : operand nibbles (unsigned)
//   casc_in   : {lt,gt,eq} from the less significant nibbles
//   casc_out  : {lt,gt,eq} including this nibble
// A local difference overrides the cascade; equal nibbles pass the cascade
// through verbatim, so malformed seeds are not corrected.
module nibble_cmp_stage
    import cmp_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_n,
    input  logic [NIBBLE_W-1:0] b_n,
    input  cascade_t            casc_in,
    output cascade_t            casc_out
);

    always_comb begin
        casc_out = casc_in;
        if (a_n > b_n) begin
            casc_out = '{lt: 1'b0, gt: 1'b1, eq: 1'b0};
        end else if (a_n < b_n) begin
            casc_out = '{lt: 1'b1, gt: 1'b0, eq: 1'b0};
        end
    end

endmodule

// File: rtl/serial_wide_comparator.sv
// serial_wide_comparator: WIDTH-bit unsigned magnitude comparator that walks
// one nibble pair per cycle, LSB first, through a single nibble_cmp_stage.
//   clk, rst_n           : clock, async active-low reset
//   start                : request a compare (accepted in IDLE or DONE)
//   a, b                 : operands, captured on accept
//   lt_in, gt_in, eq_in  : cascade seed, captured on accept
//   busy                 : high while nibbles are being processed
//   done                 : one-cycle pulse when lt/gt/eq are updated
//   lt, gt, eq           : final result, held until the next completion
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one nibble per cycle, cascade register fed back into the stage
// DONE  | result published for one cycle; start here chains a new compare
module serial_wide_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             lt_in,
    input  logic             gt_in,
    input  logic             eq_in,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             gt,
    output logic             eq
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
        $error("serial_wide_comparator: WIDTH must be a positive multiple of 4");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cascade_t         casc_q, casc_d;
    cascade_t         res_q, res_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [NIBBLE_W-1:0] a_nib, b_nib;
    cascade_t            stage_out;

    assign a_nib = a_q[cnt_q*NIBBLE_W +: NIBBLE_W];
    assign b_nib = b_q[cnt_q*NIBBLE_W +: NIBBLE_W];

    nibble_cmp_stage u_stage (
        .a_n      (a_nib),
        .b_n      (b_nib),
        .casc_in  (casc_q),
        .casc_out (stage_out)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        casc_d  = casc_q;
        res_d   = res_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    casc_d  = '{lt: lt_in, gt: gt_in, eq: eq_in};
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                casc_d = stage_out;
                if (cnt_q == CNT_LAST) begin
                    res_d   = stage_out;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status flags are registered copies of the next state.
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            casc_q  <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            casc_q  <= casc_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign lt   = res_q.lt;
    assign gt   = res_q.gt;
    assign eq   = res_q.eq;

endmodule

// File: tb/tb_serial_wide_comparator.sv
// Scoreboard bench for serial_wide_comparator (WIDTH=16 and WIDTH=4 builds).
module tb_serial_wide_comparator;

    typedef struct {
        logic [2:0] res;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic [2:0]  seed = '0;
    logic        busy, done, lt, gt, eq;

    logic        start4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [2:0]  seed4 = '0;
    logic        busy4, done4, lt4, gt4, eq4;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   busy_run = 0;
    logic [2:0] last_res = '0;
    exp_t sb[$];
    exp_t sb4[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_wide_comparator #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .lt_in(seed[2]), .gt_in(seed[1]), .eq_in(seed[0]),
        .busy(busy), .done(done), .lt(lt), .gt(gt), .eq(eq)
    );

    serial_wide_comparator #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .lt_in(seed4[2]), .gt_in(seed4[1]), .eq_in(seed4[0]),
        .busy(busy4), .done(done4), .lt(lt4), .gt(gt4), .eq(eq4)
    );

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor for the 16-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_res = '0;
            busy_run = 0;
            chk("reset_outputs", {busy, done, lt, gt, eq}, 0);
        end else begin
            if (busy) busy_run++;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("result", {lt, gt, eq}, e.res);
                    chk("done_cycle", cyc, e.cyc);
                    chk("busy_cycles", busy_run, 4);
                    chk("busy_in_done", busy, 0);
                    last_res = e.res;
                end
                busy_run = 0;
            end else begin
                chk("result_hold", {lt, gt, eq}, last_res);
            end
        end
    end

    // Monitor for the 4-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done4) begin
            if (sb4.size() == 0) begin
                chk("spurious_done4", 1, 0);
            end else begin
                e = sb4.pop_front();
                chk("result4", {lt4, gt4, eq4}, e.res);
                chk("done_cycle4", cyc, e.cyc);
            end
        end
    end

    // Drive a request at a negedge, return the index of the accepting edge.
    // start is left high; the caller decides when to drop it.
    task automatic start_cmp(input logic [15:0] av, input logic [15:0] bv,
                             input logic [2:0] sv, output int edge_idx);
        @(negedge clk);
        a = av; b = bv; seed = sv; start = 1'b1;
        @(posedge clk);
        #1;
        edge_idx = cyc;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk(name, sb.size(), 0);
        sb.delete();
    endtask

    task automatic run_cmp(input logic [15:0] av, input logic [15:0] bv,
                           input logic [2:0] sv, input logic [2:0] res);
        int e;
        start_cmp(av, bv, sv, e);
        sb.push_back('{res: res, cyc: e + 4});
        @(negedge clk);
        start = 1'b0;
        drain("drain_timeout");
    endtask

    initial begin
        int e;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_res", {lt, gt, eq}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Equal operands, seed eq.
        run_cmp(16'h1234, 16'h1234, 3'b001, 3'b001);
        // Top nibble outranks lower nibbles.
        run_cmp(16'h1000, 16'h0FFF, 3'b001, 3'b010);
        // Local difference overrides a "less" seed.
        run_cmp(16'h0001, 16'h0000, 3'b100, 3'b010);
        // All-equal nibbles pass the seed through.
        run_cmp(16'h0000, 16'h0000, 3'b100, 3'b100);
        // Malformed seeds propagate verbatim.
        run_cmp(16'hABCD, 16'hABCD, 3'b000, 3'b000);
        run_cmp(16'hABCD, 16'hABCD, 3'b110, 3'b110);
        // Unsigned: MSB set is larger.
        run_cmp(16'h0FFF, 16'hF000, 3'b001, 3'b100);

        // start pulsed again during RUN must be ignored.
        start_cmp(16'h00FF, 16'h0100, 3'b001, e);
        sb.push_back('{res: 3'b100, cyc: e + 4});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0000; seed = 3'b010; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain("drain_ignore");

        // start held through DONE: back-to-back compares.
        start_cmp(16'h8000, 16'h7FFF, 3'b001, e);
        sb.push_back('{res: 3'b010, cyc: e + 4});
        sb.push_back('{res: 3'b010, cyc: e + 9});
        repeat (5) @(posedge clk);
        #1;
        start = 1'b0;
        drain("drain_b2b");

        // Reset mid-RUN: no done for the aborted compare.
        start_cmp(16'h1234, 16'h1234, 3'b001, e);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_done", done, 0);
        chk("async_res", {lt, gt, eq}, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        run_cmp(16'hFFFF, 16'h0000, 3'b001, 3'b010);

        // WIDTH=4 build: single-cycle RUN.
        @(negedge clk);
        a4 = 4'h3; b4 = 4'h5; seed4 = 3'b001; start4 = 1'b1;
        @(posedge clk);
        #1;
        sb4.push_back('{res: 3'b100, cyc: cyc + 1});
        @(negedge clk);
        start4 = 1'b0;
        for (int i = 0; i < 10 && sb4.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk("drain4", sb4.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
